// File: rtl/regfile_param.sv
// Parametrised dual-read / single-write register file with registered reads,
// optional write-to-read bypass, optional hard-wired zero entry and a post-reset clear sweep.

module regfile_rdport #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              ren,
  input  logic              in_range,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  mem_word,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);
  logic [WIDTH-1:0] nxt;

  // Zeroing wins over bypass so out-of-range and zero-register reads never see wdata.
  always_comb begin
    nxt = mem_word;
    if (BYPASS != 0 && wen && waddr == raddr) nxt = wdata;
    if (!in_range || (ZERO_REG != 0 && raddr == '0)) nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= active && ren;
      if (active && ren) rdata <= nxt;
    end
  end
endmodule

module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  output logic              rvalid1,
  input  logic              ren2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  output logic              rvalid2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy
);
  localparam int NUM_RD = 2;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                          state;
  logic [ADDR_W-1:0]               clr_ptr;
  logic [WIDTH-1:0]                mem [DEPTH];

  logic [NUM_RD-1:0]               ren_v, rd_ok, rvalid_v;
  logic [NUM_RD-1:0][ADDR_W-1:0]   raddr_v;
  logic [NUM_RD-1:0][WIDTH-1:0]    mem_word, rdata_v;
  logic                            active, wr_ok;

  assign active  = (state == READY);
  assign wr_ok   = active && wen && ({1'b0, waddr} < DEPTH_C) &&
                   !(ZERO_REG != 0 && waddr == '0);
  assign ren_v   = {ren2, ren1};
  assign raddr_v = {raddr2, raddr1};
  assign rdata1  = rdata_v[0];
  assign rdata2  = rdata_v[1];
  assign rvalid1 = rvalid_v[0];
  assign rvalid2 = rvalid_v[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_PTR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY:   state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the clear sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)  mem[clr_ptr] <= '0;
      else if (wr_ok)      mem[waddr]   <= wdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_ok[p]    = ({1'b0, raddr_v[p]} < DEPTH_C);
    assign mem_word[p] = rd_ok[p] ? mem[raddr_v[p]] : '0;

    regfile_rdport #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .active   (active),
      .ren      (ren_v[p]),
      .in_range (rd_ok[p]),
      .raddr    (raddr_v[p]),
      .mem_word (mem_word[p]),
      .wen      (wr_ok),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata_v[p]),
      .rvalid   (rvalid_v[p])
    );
  end
endmodule

// File: tb/tb_regfile_param.sv
// Drives two regfile configurations with shared stimulus; a reference model queues expected
// read data and a negedge monitor compares it with what each instance presents.

module tb_regfile_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, ren1 = 1'b0, ren2 = 1'b0, wen = 1'b0;
  logic [3:0] raddr1 = '0, raddr2 = '0, waddr = '0;
  logic [7:0] wdata = '0;

  logic [1:0][7:0] rd1, rd2;
  logic [1:0]      rv1, rv2, bsy;

  regfile_param #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rd1[0]), .rvalid1(rv1[0]),
    .ren2(ren2), .raddr2(raddr2), .rdata2(rd2[0]), .rvalid2(rv2[0]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(bsy[0]));

  regfile_param #(.WIDTH(8), .DEPTH(12), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rd1[1]), .rvalid1(rv1[1]),
    .ren2(ren2), .raddr2(raddr2), .rdata2(rd2[1]), .rvalid2(rv2[1]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(bsy[1]));

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } item_t;

  item_t      sbq [4][$];
  int         tests = 0, fails = 0, edge_cnt = 0;
  bit         started = 1'b0;
  logic [7:0] mem_m [2][16];
  int         clr_left [2];
  logic [7:0] hold_exp [4];
  bit         busy_exp [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction
  function automatic bit byp_of(input int d);
    return d == 0;
  endfunction
  function automatic bit zero_of(input int d);
    return d == 1;
  endfunction

  function automatic logic [7:0] ref_read(input int d, input logic [3:0] a, input logic we,
                                          input logic [3:0] wa, input logic [7:0] wd);
    if (int'(a) >= depth_of(d)) return 8'h00;
    if (zero_of(d) && a == 4'd0) return 8'h00;
    if (byp_of(d) && we && wa == a) return wd;
    return mem_m[d][a];
  endfunction

  task automatic push(input int i, input logic [7:0] v);
    item_t e;
    e.cyc = edge_cnt;
    e.d   = v;
    sbq[i].push_back(e);
    hold_exp[i] = v;
  endtask

  // Called right after a posedge, while the inputs sampled by that edge are still stable.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        clr_left[d] = depth_of(d);
        busy_exp[d] = 1'b1;
        for (int k = 0; k < 16; k++) mem_m[d][k] = 8'h00;
        hold_exp[d*2]   = 8'h00;
        hold_exp[d*2+1] = 8'h00;
      end else if (clr_left[d] > 0) begin
        clr_left[d]--;
        busy_exp[d] = (clr_left[d] > 0);
      end else begin
        if (ren1) push(d*2,   ref_read(d, raddr1, wen, waddr, wdata));
        if (ren2) push(d*2+1, ref_read(d, raddr2, wen, waddr, wdata));
        if (wen && int'(waddr) < depth_of(d) && !(zero_of(d) && waddr == 4'd0))
          mem_m[d][waddr] = wdata;
      end
    end
    if (reset) started = 1'b1;
  endtask

  task automatic cyc(input logic rst, input logic r1, input int a1, input logic r2, input int a2,
                     input logic w, input int wa, input int wd);
    reset  = rst;
    ren1   = r1;  raddr1 = 4'(a1);
    ren2   = r2;  raddr2 = 4'(a2);
    wen    = w;   waddr  = 4'(wa);  wdata = 8'(wd);
    @(posedge clk);
    edge_cnt++;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops an expected read whenever one is due this cycle and checks valid/data/busy.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (bsy[d] !== busy_exp[d]) begin
          fails++;
          $display("FAIL busy dut%0d edge %0d: got %b expected %b", d, edge_cnt, bsy[d], busy_exp[d]);
        end
        for (int p = 0; p < 2; p++) begin
          int         i;
          logic       v, exp_v;
          logic [7:0] x;
          item_t      e;
          i     = d*2 + p;
          v     = (p == 0) ? rv1[d] : rv2[d];
          x     = (p == 0) ? rd1[d] : rd2[d];
          exp_v = (sbq[i].size() > 0) && (sbq[i][0].cyc == edge_cnt);
          tests++;
          if (v !== exp_v) begin
            fails++;
            $display("FAIL rvalid dut%0d port%0d edge %0d: got %b expected %b", d, p+1, edge_cnt, v, exp_v);
          end
          tests++;
          if (exp_v) begin
            e = sbq[i].pop_front();
            if (x !== e.d) begin
              fails++;
              $display("FAIL rdata dut%0d port%0d edge %0d: got %h expected %h", d, p+1, edge_cnt, x, e.d);
            end
          end else if (x !== hold_exp[i]) begin
            fails++;
            $display("FAIL hold dut%0d port%0d edge %0d: got %h expected %h", d, p+1, edge_cnt, x, hold_exp[i]);
          end
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // Requests during the clear sweep must be ignored by both instances.
    for (int k = 0; k < 10; k++) cyc(0, 1, k, 1, k, 1, 3, 8'h5A);
    idle(6);
    // Every entry reads zero after the sweep, including out-of-range ones.
    for (int k = 0; k < 16; k++) cyc(0, 1, k, 1, 15 - k, 0, 0, 0);
    // Write then read, then hold with ren low.
    cyc(0, 0, 0, 0, 0, 1, 3, 8'hA5);
    cyc(0, 1, 3, 0, 0, 0, 0, 0);
    idle(2);
    // Same-cycle write and read of one address on both ports.
    cyc(0, 0, 0, 0, 0, 1, 5, 8'h11);
    cyc(0, 1, 5, 1, 5, 1, 5, 8'h3C);
    cyc(0, 1, 5, 1, 5, 0, 0, 0);
    idle(1);
    // Entry 0 write / read.
    cyc(0, 0, 0, 0, 0, 1, 0, 8'hFF);
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    idle(1);
    // Out-of-range for the 12-deep instance.
    cyc(0, 0, 0, 0, 0, 1, 11, 8'h42);
    cyc(0, 0, 0, 0, 0, 1, 13, 8'h77);
    cyc(0, 1, 13, 1, 11, 0, 0, 0);
    idle(1);
    // Read in flight, then reset with a coincident write and read.
    cyc(0, 1, 7, 1, 3, 1, 7, 8'h99);
    cyc(1, 1, 7, 1, 3, 1, 7, 8'h55);
    idle(16);
    for (int k = 0; k < 16; k++) cyc(0, 1, k, 1, (k + 5) % 16, 0, 0, 0);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 9) < 6), $urandom_range(0, 15),
          ($urandom_range(0, 9) < 6), $urandom_range(0, 15),
          ($urandom_range(0, 1) == 1), $urandom_range(0, 15), $urandom_range(0, 255));
    end
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (sbq[i].size() != 0) begin
        fails++;
        $display("FAIL drain queue%0d: got %0d pending expected 0", i, sbq[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
